// File: rtl/zero_loop_mul_ctrl.sv
// Shift-free multiplier controller: product = a * b by repeated addition, loop ended by NOR zero flag.
// Optional FAST_ZERO_EN: a zero operand skips RUN and completes directly through DONE.
module zero_loop_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic               zero,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  assign zero = ~|cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
`ifdef FAST_ZERO_EN
          if ((a_in == '0) || (b_in == '0)) begin
            prod_d  = '0;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_DONE;
          end else begin
            a_d     = a_in;
            cnt_d   = b_in;
            acc_d   = '0;
            state_d = S_RUN;
          end
`else
          a_d     = a_in;
          cnt_d   = b_in;
          acc_d   = '0;
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        // abort takes priority over a completing loop
        if (abort) begin
          state_d = S_IDLE;
        end else if (zero) begin
          prod_d  = acc_q;
          state_d = S_DONE;
        end else begin
          acc_d = acc_q + {{WIDTH{1'b0}}, a_q};
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_RUN);
    done    = (state_q == S_DONE);
    product = prod_q;
  end

endmodule

// File: tb/tb_zero_loop_mul_ctrl.sv
// Directed bench for zero_loop_mul_ctrl; expected latencies follow FAST_ZERO_EN when defined.
module tb_zero_loop_mul_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic        zero;
  logic [15:0] product;

  int pass_cnt;
  int total_cnt;

  zero_loop_mul_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .zero    (zero),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef FAST_ZERO_EN
    if ((a == 8'd0) || (b == 8'd0)) return 1;
`endif
    return int'(b) + 2;
  endfunction

  // start for one cycle, then scramble operands; lat counts edges from acceptance to done
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int busy_n, output logic timeout);
    a_in = a;
    b_in = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in = ~a;
    b_in = 8'h5A;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 2000) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a_in = '0;
    b_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({busy, done, zero, product} !== {1'b0, 1'b0, 1'b1, 16'h0000})
      $display("FAIL reset_idle busy/done/zero/product=%b/%b/%b/%h want 0/0/1/0000", busy, done, zero, product);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, bn;
    logic to;
    run_op(8'd7, 8'd5, lat, bn, to);
    total_cnt++;
    if (to !== 1'b0 || lat != exp_lat(8'd7, 8'd5))
      $display("FAIL basic_latency got %0d want %0d (timeout=%b)", lat, exp_lat(8'd7, 8'd5), to);
    else pass_cnt++;
    total_cnt++;
    if (bn != 6) $display("FAIL basic_busy_cycles got %0d want 6", bn);
    else pass_cnt++;
    total_cnt++;
    if (product !== 16'h0023) $display("FAIL basic_product got %h want 0023", product);
    else pass_cnt++;
    total_cnt++;
    if (zero !== 1'b1) $display("FAIL basic_zero_at_done got %b want 1", zero);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, busy, product} !== {1'b0, 1'b0, 16'h0023})
      $display("FAIL basic_hold done/busy/product=%b/%b/%h want 0/0/0023", done, busy, product);
    else pass_cnt++;
  endtask

  task automatic test_max();
    int lat, bn;
    logic to;
    run_op(8'd255, 8'd255, lat, bn, to);
    total_cnt++;
    if (to !== 1'b0 || lat != 257) $display("FAIL max_latency got %0d want 257 (timeout=%b)", lat, to);
    else pass_cnt++;
    total_cnt++;
    if (product !== 16'hFE01) $display("FAIL max_product got %h want fe01", product);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_zero_operand();
    int lat, bn;
    logic to;
    run_op(8'd9, 8'd0, lat, bn, to);
    total_cnt++;
    if (to !== 1'b0 || lat != exp_lat(8'd9, 8'd0))
      $display("FAIL b0_latency got %0d want %0d (timeout=%b)", lat, exp_lat(8'd9, 8'd0), to);
    else pass_cnt++;
    total_cnt++;
    if (product !== 16'h0000) $display("FAIL b0_product got %h want 0000", product);
    else pass_cnt++;
    tick();
    run_op(8'd1, 8'd3, lat, bn, to);
    tick();
    run_op(8'd0, 8'd200, lat, bn, to);
    total_cnt++;
    if (to !== 1'b0 || lat != exp_lat(8'd0, 8'd200))
      $display("FAIL a0_latency got %0d want %0d (timeout=%b)", lat, exp_lat(8'd0, 8'd200), to);
    else pass_cnt++;
    total_cnt++;
    if (product !== 16'h0000) $display("FAIL a0_product got %h want 0000", product);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    int lat, bn;
    logic to;
    logic seen;
    run_op(8'd6, 8'd7, lat, bn, to);
    tick();
    a_in = 8'd3;
    b_in = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if ({busy, done, product} !== {1'b0, 1'b0, 16'd42})
      $display("FAIL abort_idle busy/done/product=%b/%b/%h want 0/0/002a", busy, done, product);
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_no_done got activity=%b want 0", seen);
    else pass_cnt++;
    run_op(8'd4, 8'd3, lat, bn, to);
    total_cnt++;
    if (to !== 1'b0 || lat != 5 || product !== 16'd12)
      $display("FAIL abort_restart lat=%0d product=%h want 5/000c", lat, product);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_abort_zero();
    int n;
    a_in = 8'd5;
    b_in = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!zero && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if ({busy, zero} !== 2'b11 || n != 2)
      $display("FAIL abz_reach busy/zero=%b/%b after %0d want 1/1 after 2", busy, zero, n);
    else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if ({busy, done, product} !== {1'b0, 1'b0, 16'd12})
      $display("FAIL abz_abort_wins busy/done/product=%b/%b/%h want 0/0/000c", busy, done, product);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL abz_no_late_done got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t_prev;
    int ndone;
    t_prev = -1;
    ndone = 0;
    a_in = 8'd2;
    b_in = 8'd3;
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        total_cnt++;
        if (product !== 16'd6) $display("FAIL b2b_product got %h want 0006", product);
        else pass_cnt++;
        if (t_prev >= 0) begin
          total_cnt++;
          if (i - t_prev != 6) $display("FAIL b2b_period got %0d want 6", i - t_prev);
          else pass_cnt++;
        end else begin
          total_cnt++;
          if (i != 5) $display("FAIL b2b_first got %0d want 5", i);
          else pass_cnt++;
        end
        t_prev = i;
        ndone++;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (ndone != 5) $display("FAIL b2b_count got %0d want 5", ndone);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid_run();
    a_in = 8'd3;
    b_in = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, zero, product} !== {1'b0, 1'b0, 1'b1, 16'h0000})
      $display("FAIL reset_async busy/done/zero/product=%b/%b/%b/%h want 0/0/1/0000", busy, done, zero, product);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({busy, done, zero} !== 3'b001) $display("FAIL reset_release busy/done/zero=%b%b%b want 001", busy, done, zero);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero_operand();
    test_abort();
    test_abort_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
